// File: rtl/fifo_pkg.sv
// Shared defaults and gray-code helpers for the async FIFO write/read controllers.
package fifo_pkg;

   localparam int unsigned ADDR_W_DEF = 3;
   localparam int unsigned DEPTH_DEF  = 8;

   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   // Each binary bit is the XOR of its gray bit and every higher gray bit.
   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b = g;
      for (int unsigned s = 1; s < 32; s++) begin
         b = b ^ (g >> s);
      end
      return b;
   endfunction

endpackage

// File: rtl/fifo_sync_2ff.sv
// Two-flop synchroniser for a gray-coded pointer crossing into the local clock domain.
module fifo_sync_2ff #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] meta,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer, full/level/overflow controller for the async FIFO.
// Optional almost_full output enabled by defining FIFO_ALMOST_FULL_EN.
module fifo_wr_ctrl
   import fifo_pkg::*;
#(
   parameter int unsigned DEPTH     = DEPTH_DEF,
   parameter int unsigned ADDR_W    = ADDR_W_DEF
`ifdef FIFO_ALMOST_FULL_EN
   ,
   parameter int unsigned AF_THRESH = 6
`endif
) (
   input  logic              wr_clk,
   input  logic              wr_rst_n,
   input  logic              wr_en_i,
   input  logic [ADDR_W:0]   rd_gray_i,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [ADDR_W:0]   wr_gray_o,
   output logic              full,
   output logic [ADDR_W:0]   wr_level_o,
   output logic              overflow_o
`ifdef FIFO_ALMOST_FULL_EN
   ,
   output logic              almost_full
`endif
);

   localparam int unsigned PW = ADDR_W + 1;

   if (DEPTH != (1 << ADDR_W)) begin : g_depth_check
      $error("fifo_wr_ctrl: DEPTH must equal 2**ADDR_W");
   end

   logic [PW-1:0] wr_bin;
   logic [PW-1:0] wr_bin_next;
   logic [PW-1:0] gray_next;
   logic [PW-1:0] rq1;
   logic [PW-1:0] rq2;
   logic [PW-1:0] full_match;
   logic          accept;

   fifo_sync_2ff #(
      .WIDTH(PW)
   ) u_rd_sync (
      .clk   (wr_clk),
      .rst_n (wr_rst_n),
      .d     (rd_gray_i),
      .meta  (rq1),
      .q     (rq2)
   );

   always_comb begin
      accept      = wr_en_i & ~full;
      wr_bin_next = wr_bin + PW'(accept);
      gray_next   = PW'(bin2gray(32'(wr_bin_next)));
      // Full when the write pointer is exactly one lap ahead: top two gray bits inverted.
      full_match  = {~rq2[ADDR_W:ADDR_W-1], rq2[ADDR_W-2:0]};
   end

   always_ff @(posedge wr_clk or negedge wr_rst_n) begin
      if (!wr_rst_n) begin
         wr_bin     <= '0;
         wr_gray_o  <= '0;
         full       <= 1'b0;
         overflow_o <= 1'b0;
      end else begin
         wr_bin    <= wr_bin_next;
         wr_gray_o <= gray_next;
         full      <= (gray_next == full_match);
         if (wr_en_i && full) begin
            overflow_o <= 1'b1;
         end
      end
   end

   assign wr_addr    = wr_bin[ADDR_W-1:0];
   assign wr_level_o = wr_bin - PW'(gray2bin(32'(rq2)));

`ifdef FIFO_ALMOST_FULL_EN
   logic [PW-1:0] level_next;

   // rq1 is what rq2 becomes on this edge, so the flag lines up with the next-state level.
   assign level_next = wr_bin_next - PW'(gray2bin(32'(rq1)));

   always_ff @(posedge wr_clk or negedge wr_rst_n) begin
      if (!wr_rst_n) begin
         almost_full <= 1'b0;
      end else begin
         almost_full <= (32'(level_next) >= AF_THRESH);
      end
   end
`else
   logic rq1_unused;
   assign rq1_unused = ^rq1;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed self-checking bench for fifo_wr_ctrl (DEPTH=8, ADDR_W=3).
module tb_fifo_wr_ctrl;

   logic       wr_clk;
   logic       wr_rst_n;
   logic       wr_en_i;
   logic [3:0] rd_gray_i;
   logic [2:0] wr_addr;
   logic [3:0] wr_gray_o;
   logic       full;
   logic [3:0] wr_level_o;
   logic       overflow_o;
`ifdef FIFO_ALMOST_FULL_EN
   logic       almost_full;
`endif

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   fifo_wr_ctrl #(
      .DEPTH     (8),
      .ADDR_W    (3)
`ifdef FIFO_ALMOST_FULL_EN
      ,
      .AF_THRESH (6)
`endif
   ) dut (
      .wr_clk      (wr_clk),
      .wr_rst_n    (wr_rst_n),
      .wr_en_i     (wr_en_i),
      .rd_gray_i   (rd_gray_i),
      .wr_addr     (wr_addr),
      .wr_gray_o   (wr_gray_o),
      .full        (full),
      .wr_level_o  (wr_level_o),
      .overflow_o  (overflow_o)
`ifdef FIFO_ALMOST_FULL_EN
      ,
      .almost_full (almost_full)
`endif
   );

   initial wr_clk = 1'b0;
   always #5 wr_clk = ~wr_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] b2g(input logic [3:0] b);
      return b ^ {1'b0, b[3:1]};
   endfunction

   function automatic logic [3:0] g2b(input logic [3:0] g);
      logic [3:0] b;
      b[3] = g[3];
      for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   task automatic tick();
      @(posedge wr_clk);
      #1;
   endtask

   task automatic do_reset();
      wr_en_i   = 1'b0;
      rd_gray_i = 4'h0;
      wr_rst_n  = 1'b0;
      #3;
      wr_rst_n  = 1'b1;
      tick();
   endtask

   logic [3:0] gray_tab [0:8];
   logic [3:0] wcnt, rd_ptr, m_rq1, m_rq2;

   initial begin
      gray_tab[0] = 4'h0; gray_tab[1] = 4'h1; gray_tab[2] = 4'h3;
      gray_tab[3] = 4'h2; gray_tab[4] = 4'h6; gray_tab[5] = 4'h7;
      gray_tab[6] = 4'h5; gray_tab[7] = 4'h4; gray_tab[8] = 4'hC;

      wr_en_i   = 1'b0;
      rd_gray_i = 4'h0;
      wr_rst_n  = 1'b0;
      #2;
      check("rst_addr",     32'(wr_addr),    32'h0);
      check("rst_gray",     32'(wr_gray_o),  32'h0);
      check("rst_full",     32'(full),       32'h0);
      check("rst_level",    32'(wr_level_o), 32'h0);
      check("rst_overflow", 32'(overflow_o), 32'h0);
      #2;
      wr_rst_n = 1'b1;
      tick();

      // Fill with 8 writes.
      for (int k = 1; k <= 8; k++) begin
         wr_en_i = 1'b1;
         tick();
         check("fill_addr",  32'(wr_addr),    32'(k % 8));
         check("fill_gray",  32'(wr_gray_o),  32'(gray_tab[k]));
         check("fill_full",  32'(full),       (k == 8) ? 32'h1 : 32'h0);
         check("fill_level", 32'(wr_level_o), 32'(k));
      end
      check("fill_no_ovf", 32'(overflow_o), 32'h0);

      // Writes while full are dropped and set the sticky overflow.
      for (int k = 0; k < 3; k++) begin
         wr_en_i = 1'b1;
         tick();
         check("ovf_addr", 32'(wr_addr),    32'h0);
         check("ovf_gray", 32'(wr_gray_o),  32'hC);
         check("ovf_full", 32'(full),       32'h1);
         check("ovf_flag", 32'(overflow_o), 32'h1);
      end
      wr_en_i = 1'b0;
      tick();
      check("ovf_sticky", 32'(overflow_o), 32'h1);

      // Remote read releases full on the third edge.
      rd_gray_i = 4'h1;
      tick();
      check("rel_full_e1",  32'(full),       32'h1);
      check("rel_level_e1", 32'(wr_level_o), 32'h8);
      tick();
      check("rel_full_e2",  32'(full),       32'h1);
      tick();
      check("rel_full_e3",  32'(full),       32'h0);
      check("rel_level_e3", 32'(wr_level_o), 32'h7);

      // Async reset mid-burst.
      do_reset();
      for (int k = 0; k < 5; k++) begin
         wr_en_i = 1'b1;
         tick();
      end
      wr_en_i = 1'b0;
      check("mid_level", 32'(wr_level_o), 32'h5);
      #2;
      wr_rst_n = 1'b0;
      #1;
      check("arst_addr",     32'(wr_addr),    32'h0);
      check("arst_gray",     32'(wr_gray_o),  32'h0);
      check("arst_full",     32'(full),       32'h0);
      check("arst_level",    32'(wr_level_o), 32'h0);
      check("arst_overflow", 32'(overflow_o), 32'h0);
      #2;
      wr_rst_n = 1'b1;
      wr_en_i  = 1'b1;
      check("post_rst_addr", 32'(wr_addr), 32'h0);
      tick();
      check("post_rst_addr1", 32'(wr_addr),   32'h1);
      check("post_rst_gray1", 32'(wr_gray_o), 32'h1);

      // Continuous writes with the read pointer trailing; pointer wraps repeatedly.
      do_reset();
      wcnt = 4'h0; rd_ptr = 4'h0; m_rq1 = 4'h0; m_rq2 = 4'h0;
      for (int i = 0; i < 40; i++) begin
         wr_en_i   = 1'b1;
         rd_gray_i = b2g(rd_ptr);
         tick();
         wcnt  = wcnt + 4'h1;
         m_rq2 = m_rq1;
         m_rq1 = rd_gray_i;
         check("wrap_full",  32'(full),       32'h0);
         check("wrap_addr",  32'(wr_addr),    32'(wcnt[2:0]));
         check("wrap_gray",  32'(wr_gray_o),  32'(b2g(wcnt)));
         check("wrap_level", 32'(wr_level_o), 32'(4'(wcnt - g2b(m_rq2))));
         if (i >= 3) rd_ptr = rd_ptr + 4'h1;
      end
      wr_en_i = 1'b0;

`ifdef FIFO_ALMOST_FULL_EN
      do_reset();
      check("af_rst", 32'(almost_full), 32'h0);
      for (int k = 1; k <= 6; k++) begin
         wr_en_i = 1'b1;
         tick();
         check("af_rise", 32'(almost_full), (k >= 6) ? 32'h1 : 32'h0);
      end
      wr_en_i   = 1'b0;
      rd_gray_i = b2g(4'h1);
      tick();
      check("af_hold",       32'(almost_full), 32'h1);
      check("af_hold_level", 32'(wr_level_o),  32'h6);
      tick();
      check("af_fall",       32'(almost_full), 32'h0);
      check("af_fall_level", 32'(wr_level_o),  32'h5);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
